// File: rtl/avic_edge_slope_if.sv
// Divider handshake bundle between the edge-slope setup stage (master)
// and the shared iterative divider (slave).
interface avic_edge_slope_if #(
  parameter int WID = 28
);
  logic           div_ld;
  logic           div_sgn;
  logic           div_abort;
  logic [WID-1:0] div_a;
  logic [WID-1:0] div_b;
  logic [WID-1:0] div_q;
  logic           div_done;
  logic           div_idle;

  modport master (
    output div_ld, div_sgn, div_abort, div_a, div_b,
    input  div_q, div_done, div_idle
  );

  modport slave (
    input  div_ld, div_sgn, div_abort, div_a, div_b,
    output div_q, div_done, div_idle
  );
endinterface

// File: rtl/avic_edge_slope.sv
// Triangle edge-slope setup: computes dx/dy for edges 0-1, 1-2, 0-2 as
// signed fixed-point values by sequencing the shared iterative divider.
// Horizontal edges (dy == 0) skip the divider and are reported in flat.
module avic_edge_slope #(
  parameter int WID  = 28,
  parameter int CW   = 11,
  parameter int FRAC = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           abort,
  input  logic [CW-1:0]  x0,
  input  logic [CW-1:0]  y0,
  input  logic [CW-1:0]  x1,
  input  logic [CW-1:0]  y1,
  input  logic [CW-1:0]  x2,
  input  logic [CW-1:0]  y2,
  output logic           busy,
  output logic           done,
  output logic [WID-1:0] s01,
  output logic [WID-1:0] s12,
  output logic [WID-1:0] s02,
  output logic [2:0]     flat,
  avic_edge_slope_if.master dbus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_STORE = 3'd4,
    ST_FIN   = 3'd5
  } state_t;

  state_t             state_r;
  state_t             next_s;
  logic [1:0]         edge_r;
  logic               wait_arm_r;
  logic [2:0][CW-1:0] vx_r;
  logic [2:0][CW-1:0] vy_r;
  logic [CW-1:0]      xa_s, xb_s, ya_s, yb_s;
  logic [CW:0]        dx_s, dy_s;
  logic               dy_zero_s;
  logic               busy_nx_s;
  logic               done_nx_s;
  logic               ld_nx_s;
  logic               dabort_nx_s;
  logic               slope_we_s;
  logic [WID-1:0]     slope_val_s;

  // Select the endpoints of the current edge and form signed deltas.
  always_comb begin
    xa_s = vx_r[0];
    xb_s = vx_r[1];
    ya_s = vy_r[0];
    yb_s = vy_r[1];
    case (edge_r)
      2'd0: begin xa_s = vx_r[0]; xb_s = vx_r[1]; ya_s = vy_r[0]; yb_s = vy_r[1]; end
      2'd1: begin xa_s = vx_r[1]; xb_s = vx_r[2]; ya_s = vy_r[1]; yb_s = vy_r[2]; end
      2'd2: begin xa_s = vx_r[0]; xb_s = vx_r[2]; ya_s = vy_r[0]; yb_s = vy_r[2]; end
      default: begin xa_s = vx_r[0]; xb_s = vx_r[1]; ya_s = vy_r[0]; yb_s = vy_r[1]; end
    endcase
    dx_s      = {1'b0, xb_s} - {1'b0, xa_s};
    dy_s      = {1'b0, yb_s} - {1'b0, ya_s};
    dy_zero_s = (dy_s == {(CW+1){1'b0}});
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state logic; abort from any active state returns to IDLE.
  always_comb begin
    next_s = state_r;
    if ((state_r != ST_IDLE) && abort) begin
      next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:  if (start && !abort) next_s = ST_SETUP; else next_s = ST_IDLE;
        ST_SETUP: if (dy_zero_s) next_s = ST_STORE; else next_s = ST_ISSUE;
        // div_ld is high for the single ISSUE cycle in which the load happens
        ST_ISSUE: if (dbus.div_ld) next_s = ST_WAIT; else next_s = ST_ISSUE;
        // the first WAIT cycle may still see the divider's idle-done level
        ST_WAIT:  if (wait_arm_r && dbus.div_done) next_s = ST_STORE; else next_s = ST_WAIT;
        ST_STORE: if (edge_r == 2'd2) next_s = ST_FIN; else next_s = ST_SETUP;
        ST_FIN:   next_s = ST_IDLE;
        default:  next_s = ST_IDLE;
      endcase
    end
  end

  // Next values of the registered control outputs and the slope write port.
  always_comb begin
    busy_nx_s   = (next_s != ST_IDLE);
    done_nx_s   = (state_r == ST_FIN) && !abort;
    // load is registered, so it is raised one cycle ahead using the
    // divider's idle flag; the pulse lands inside the ISSUE cycle
    ld_nx_s     = (next_s == ST_ISSUE) && dbus.div_idle;
    dabort_nx_s = (state_r != ST_IDLE) && abort;
    slope_we_s  = ((state_r == ST_SETUP) || (state_r == ST_WAIT)) && (next_s == ST_STORE);
    if (state_r == ST_WAIT) begin
      slope_val_s = dbus.div_q;
    end else begin
      slope_val_s = {WID{1'b0}};
    end
  end

  // Registered outputs and datapath: vertex capture, operands, slopes.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy           <= 1'b0;
      done           <= 1'b0;
      dbus.div_ld    <= 1'b0;
      dbus.div_sgn   <= 1'b0;
      dbus.div_abort <= 1'b0;
      dbus.div_a     <= {WID{1'b0}};
      dbus.div_b     <= {WID{1'b0}};
      s01            <= {WID{1'b0}};
      s12            <= {WID{1'b0}};
      s02            <= {WID{1'b0}};
      flat           <= 3'b000;
      edge_r         <= 2'd0;
      wait_arm_r     <= 1'b0;
      vx_r           <= {(3*CW){1'b0}};
      vy_r           <= {(3*CW){1'b0}};
    end else begin
      busy           <= busy_nx_s;
      done           <= done_nx_s;
      dbus.div_ld    <= ld_nx_s;
      dbus.div_sgn   <= busy_nx_s;
      dbus.div_abort <= dabort_nx_s;
      wait_arm_r     <= (state_r == ST_WAIT);
      case (state_r)
        ST_IDLE: begin
          if (next_s == ST_SETUP) begin
            vx_r   <= {x2, x1, x0};
            vy_r   <= {y2, y1, y0};
            edge_r <= 2'd0;
            flat   <= 3'b000;
          end
        end
        ST_SETUP: begin
          if (next_s == ST_STORE) begin
            flat[edge_r] <= 1'b1;
          end else if (next_s == ST_ISSUE) begin
            dbus.div_a <= {{(WID-CW-1){dx_s[CW]}}, dx_s} << FRAC;
            dbus.div_b <= {{(WID-CW-1){dy_s[CW]}}, dy_s};
          end
        end
        ST_STORE: begin
          if (next_s == ST_SETUP) begin
            edge_r <= edge_r + 2'd1;
          end
        end
        default: ;
      endcase
      if (slope_we_s) begin
        case (edge_r)
          2'd0:    s01 <= slope_val_s;
          2'd1:    s12 <= slope_val_s;
          2'd2:    s02 <= slope_val_s;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_avic_edge_slope.sv
// Scoreboard bench for avic_edge_slope with a behavioural divider model.
module tb_avic_edge_slope;
  localparam int WID = 28;
  localparam int CW  = 11;

  typedef struct {
    logic [WID-1:0] s01;
    logic [WID-1:0] s12;
    logic [WID-1:0] s02;
    logic [2:0]     flat;
    int             due;
    int             ld_base;
    int             nld;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [CW-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0, x2 = '0, y2 = '0;
  logic busy, done;
  logic [WID-1:0] s01, s12, s02;
  logic [2:0] flat;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int total_ld = 0;
  logic idle_hold = 1'b0;
  exp_t sb[$];

  logic [5:0]     dcnt = '0;
  logic [WID-1:0] dq = '0;

  avic_edge_slope_if #(.WID(WID)) dbus_if ();

  avic_edge_slope #(.WID(WID), .CW(CW), .FRAC(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .x2(x2), .y2(y2),
    .busy(busy), .done(done), .s01(s01), .s12(s12), .s02(s02),
    .flat(flat), .dbus(dbus_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // divider model: done WID+3 cycles after the load cycle
  always @(posedge clk) begin
    if (rst || dbus_if.div_abort) begin
      dcnt <= '0;
    end else if (dbus_if.div_ld) begin
      dcnt <= 6'(WID + 2);
      if (dbus_if.div_b != '0) dq <= $signed(dbus_if.div_a) / $signed(dbus_if.div_b);
    end else if (dcnt != '0) begin
      dcnt <= dcnt - 6'd1;
    end
  end
  assign dbus_if.div_q    = dq;
  assign dbus_if.div_done = (dcnt == '0) && !dbus_if.div_ld;
  assign dbus_if.div_idle = (dcnt == '0) && !idle_hold;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WID-1:0] ref_slope(input int xa, input int ya, input int xb, input int yb);
    int dx, dy, num;
    dx = xb - xa;
    dy = yb - ya;
    if (dy == 0) return '0;
    num = dx * 65536;
    return WID'(num / dy);
  endfunction

  function automatic int edge_cost(input int ya, input int yb);
    return (ya == yb) ? 2 : WID + 6;
  endfunction

  task automatic monitor();
    exp_t e;
    logic prev_ld = 1'b0;
    logic prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (dbus_if.div_ld) begin
        check_eq("ld_width", prev_ld, 0);
        total_ld++;
      end
      if (done) begin
        check_eq("done_width", prev_done, 0);
        check_eq("done_busy", busy, 0);
        if (sb.size() == 0) begin
          check_eq("spurious_done", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          check_eq("s01", s01, e.s01);
          check_eq("s12", s12, e.s12);
          check_eq("s02", s02, e.s02);
          check_eq("flat", flat, e.flat);
          check_eq("latency", cyc, e.due);
          check_eq("ld_count", total_ld - e.ld_base, e.nld);
        end
      end
      prev_ld = dbus_if.div_ld;
      prev_done = done;
    end
  endtask

  task automatic launch(input int ax0, input int ay0, input int ax1, input int ay1,
                        input int ax2, input int ay2, input bit track, input bit hold,
                        input int extra, output int t0);
    exp_t e;
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (busy) check_eq("idle_timeout", busy, 0);
    x0 = CW'(ax0); y0 = CW'(ay0); x1 = CW'(ax1); y1 = CW'(ay1); x2 = CW'(ax2); y2 = CW'(ay2);
    start = 1'b1;
    idle_hold = hold;
    t0 = cyc;
    if (track) begin
      e.s01  = ref_slope(ax0, ay0, ax1, ay1);
      e.s12  = ref_slope(ax1, ay1, ax2, ay2);
      e.s02  = ref_slope(ax0, ay0, ax2, ay2);
      e.flat = {ay0 == ay2, ay1 == ay2, ay0 == ay1};
      e.nld  = 3 - ((ay0 == ay2) ? 1 : 0) - ((ay1 == ay2) ? 1 : 0) - ((ay0 == ay1) ? 1 : 0);
      e.due  = t0 + 2 + edge_cost(ay0, ay1) + edge_cost(ay1, ay2) + edge_cost(ay0, ay2) + extra;
      e.ld_base = total_ld;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_after_start", busy, 1);
    check_eq("sgn_while_busy", dbus_if.div_sgn, 1);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done) check_eq("done_timeout", done, 1);
  endtask

  task automatic check_cleared(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_s01"}, s01, 0);
    check_eq({tag, "_s12"}, s12, 0);
    check_eq({tag, "_s02"}, s02, 0);
    check_eq({tag, "_flat"}, flat, 0);
    check_eq({tag, "_ld"}, dbus_if.div_ld, 0);
    check_eq({tag, "_sgn"}, dbus_if.div_sgn, 0);
    check_eq({tag, "_dabort"}, dbus_if.div_abort, 0);
    check_eq({tag, "_diva"}, dbus_if.div_a, 0);
    check_eq({tag, "_divb"}, dbus_if.div_b, 0);
  endtask

  initial begin
    int t0;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;
    fork
      monitor();
    join_none

    launch(0, 0, 100, 50, 100, 100, 1'b1, 1'b0, 0, t0);
    wait_done(200);
    launch(100, 0, 0, 200, 0, 0, 1'b1, 1'b0, 0, t0);
    wait_done(200);
    launch(5, 37, 900, 37, 2047, 37, 1'b1, 1'b0, 0, t0);
    wait_done(200);
    launch(10, 10, 11, 13, 9, 13, 1'b1, 1'b0, 0, t0);
    wait_done(200);
    launch(0, 0, 2047, 1, 0, 2047, 1'b1, 1'b0, 0, t0);
    wait_done(200);

    // abort 10 cycles into the first WAIT
    launch(0, 0, 100, 50, 100, 100, 1'b0, 1'b0, 0, t0);
    repeat (12) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("abort_pulse", dbus_if.div_abort, 1);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_ld", dbus_if.div_ld, 0);
    @(negedge clk);
    check_eq("abort_pulse_end", dbus_if.div_abort, 0);
    repeat (120) @(negedge clk);

    launch(0, 0, 100, 50, 100, 100, 1'b1, 1'b0, 0, t0);
    wait_done(200);

    // reset in the middle of the first WAIT
    launch(0, 0, 100, 50, 100, 100, 1'b0, 1'b0, 0, t0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_cleared("midrst");
    rst = 1'b0;

    // abort and start together while idle
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check_eq("idle_abort_busy", busy, 0);
    check_eq("idle_abort_pulse", dbus_if.div_abort, 0);

    // divider busy for the first ISSUE cycles, plus a start pulse while busy
    launch(0, 0, 100, 50, 100, 100, 1'b1, 1'b1, 6, t0);
    repeat (5) @(negedge clk);
    check_eq("ld_held_low", dbus_if.div_ld, 0);
    @(negedge clk);
    idle_hold = 1'b0;
    repeat (13) @(negedge clk);
    x0 = 11'd7; y0 = 11'd300; x1 = 11'd1; y1 = 11'd2; x2 = 11'd3; y2 = 11'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(200);

    for (int i = 0; i < 4; i++) begin
      launch($urandom_range(0, 2047), $urandom_range(0, 3), $urandom_range(0, 2047),
             $urandom_range(0, 3), $urandom_range(0, 2047), $urandom_range(0, 3),
             1'b1, 1'b0, 0, t0);
      wait_done(200);
    end

    repeat (3) @(negedge clk);
    check_eq("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
